shift_arbiter: RTL

Shares one SHIFT32 barrel shifter between two requesters (e.g. ALU shift path and address/immediate path). Round-robin arbitration picks a request and latches its operands onto registered shifter inputs. It holds them for a programmable settle time, then captures Y into a result register. The result is returned with a valid/ready handshake and a requester-ID tag.

---
 rtl/shift_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external 32-bit barrel shifter between two
// requesters. A round-robin arbiter latches the winner's operands into
// registered shifter inputs, holds them for SETTLE_CYCLES, captures the
// shifter output and returns it through a valid/ready handshake tagged
// with the owning requester's ID.
module shift_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] s0,
    input  logic                  lnr0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] d1,
    input  logic [DATA_WIDTH-1:0] s1,
    input  logic                  lnr1,
    output logic                  gnt1,
    output logic [DATA_WIDTH-1:0] sh_d,
    output logic [DATA_WIDTH-1:0] sh_s,
    output logic                  sh_lnr,
    input  logic [DATA_WIDTH-1:0] sh_y,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  res_id,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter reload: the capture happens on the edge where the counter is
    // already zero, so loading N-1 yields exactly N edges of settle time.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    last_id_q, last_id_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic [DATA_WIDTH-1:0]   sh_d_q, sh_d_d;
    logic [DATA_WIDTH-1:0]   sh_s_q, sh_s_d;
    logic                    sh_lnr_q, sh_lnr_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    res_id_q, res_id_d;
    logic                    res_valid_q, res_valid_d;
    logic                    busy_q, busy_d;

    logic                    arb_en_s;
    logic                    win_valid_s;
    logic                    win_id_s;
    logic [DATA_WIDTH-1:0]   win_d_s;
    logic [DATA_WIDTH-1:0]   win_s_s;
    logic                    win_lnr_s;

    // Round-robin arbitration: decide whether this edge may grant and who wins.
    always_comb begin
        arb_en_s    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
        win_valid_s = arb_en_s && (req0 || req1);
        if (req0 && req1) begin
            win_id_s = ~last_id_q;
        end else if (req0) begin
            win_id_s = 1'b0;
        end else begin
            win_id_s = 1'b1;
        end
        if (win_id_s) begin
            win_d_s   = d1;
            win_s_s   = s1;
            win_lnr_s = lnr1;
        end else begin
            win_d_s   = d0;
            win_s_s   = s0;
            win_lnr_s = lnr0;
        end
    end

    // Next-state and next-output logic for the IDLE/DRIVE/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_id_d   = last_id_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        sh_d_d      = sh_d_q;
        sh_s_d      = sh_s_q;
        sh_lnr_d    = sh_lnr_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d       = sh_y;
                    res_id_d    = last_id_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A win (only possible in IDLE or in DONE being drained) overrides
        // the IDLE fall-through so DONE can go straight back to DRIVE.
        if (win_valid_s) begin
            sh_d_d    = win_d_s;
            sh_s_d    = win_s_s;
            sh_lnr_d  = win_lnr_s;
            gnt0_d    = ~win_id_s;
            gnt1_d    = win_id_s;
            last_id_d = win_id_s;
            cnt_d     = CNT_LOAD;
            state_d   = ST_DRIVE;
        end else begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any in-flight operation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_id_q   <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            sh_d_q      <= '0;
            sh_s_q      <= '0;
            sh_lnr_q    <= 1'b0;
            res_q       <= '0;
            res_id_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            sh_d_q      <= sh_d_d;
            sh_s_q      <= sh_s_d;
            sh_lnr_q    <= sh_lnr_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sh_d      = sh_d_q;
    assign sh_s      = sh_s_q;
    assign sh_lnr    = sh_lnr_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;

endmodule
